// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Purpose  : Shared RV32I decode definitions (major opcodes, immediate kinds)
//  Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen
//  Purpose  : Combinational immediate extraction, type and illegal-opcode flag
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_type_e       o_immType,
    output logic            o_illegal
);

    logic [31:0] w_imm32;

    // Decode the major opcode into an immediate format; R-type carries none
    always_comb begin
        w_imm32   = '0;
        o_immType = IMM_NONE;
        o_illegal = 1'b0;
        case (i_instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                o_immType = IMM_I;
                w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OPC_STORE: begin
                o_immType = IMM_S;
                w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                o_immType = IMM_B;
                w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_immType = IMM_U;
                w_imm32   = {i_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                o_immType = IMM_J;
                w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
            end
            OPC_OP: begin
                o_immType = IMM_NONE;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    // Every format is sign-extended from instruction bit 31
    assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : Instruction decode with ID/EX pipeline register and handshakes
//  Options  : ID_WB_BYPASS_EN - forward writeback data into captured/held
//             operands
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage
    import rv32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_instrValid,
    output logic                  o_instrReady,
    input  logic [XLEN-1:0]       i_instr,
    input  logic [XLEN-1:0]       i_pc,
    output logic [REG_ADDR_W-1:0] o_rs1Addr,
    output logic [REG_ADDR_W-1:0] o_rs2Addr,
    input  logic [XLEN-1:0]       i_rs1Data,
    input  logic [XLEN-1:0]       i_rs2Data,
    input  logic                  i_wbEn,
    input  logic [REG_ADDR_W-1:0] i_wbAddr,
    input  logic [XLEN-1:0]       i_wbData,
    output logic                  o_exValid,
    input  logic                  i_exReady,
    output logic [XLEN-1:0]       o_exPc,
    output logic [XLEN-1:0]       o_exRs1Data,
    output logic [XLEN-1:0]       o_exRs2Data,
    output logic [XLEN-1:0]       o_exImm,
    output logic [REG_ADDR_W-1:0] o_exRd,
    output logic [6:0]            o_exOpcode,
    output logic [2:0]            o_exFunct3,
    output logic                  o_exFunct7b5,
    output logic                  o_exIllegal
);

    logic [XLEN-1:0]       w_imm;
    imm_type_e             w_immType;
    logic                  w_illegal;
    logic                  w_accept;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [XLEN-1:0]       w_rs1Cap;
    logic [XLEN-1:0]       w_rs2Cap;

    logic                  r_exValid;
    logic [XLEN-1:0]       r_exPc;
    logic [XLEN-1:0]       r_exRs1Data;
    logic [XLEN-1:0]       r_exRs2Data;
    logic [XLEN-1:0]       r_exImm;
    logic [REG_ADDR_W-1:0] r_exRd;
    logic [6:0]            r_exOpcode;
    logic [2:0]            r_exFunct3;
    logic                  r_exFunct7b5;
    logic                  r_exIllegal;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr   (i_instr),
        .o_imm     (w_imm),
        .o_immType (w_immType),
        .o_illegal (w_illegal)
    );

    // Register-file addresses come straight from the instruction word
    assign o_rs1Addr = i_instr[19:15];
    assign o_rs2Addr = i_instr[24:20];

    // A flush redirects fetch, so nothing is taken that cycle
    assign o_instrReady = !i_flush && (!r_exValid || i_exReady);
    assign w_accept     = i_instrValid && o_instrReady;

    // Stores, branches and illegal opcodes have no destination
    assign w_rd = (w_illegal || w_immType == IMM_S || w_immType == IMM_B)
                ? '0 : i_instr[11:7];

`ifdef ID_WB_BYPASS_EN
    logic [REG_ADDR_W-1:0] r_rs1Idx;
    logic [REG_ADDR_W-1:0] r_rs2Idx;

    // Same-cycle writeback wins over the stale register-file read; x0 never
    assign w_rs1Cap = (i_wbEn && i_wbAddr != '0 && i_wbAddr == o_rs1Addr)
                    ? i_wbData : i_rs1Data;
    assign w_rs2Cap = (i_wbEn && i_wbAddr != '0 && i_wbAddr == o_rs2Addr)
                    ? i_wbData : i_rs2Data;

    // Remember source indices so a stalled entry can pick up later writebacks
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rs1Idx <= '0;
            r_rs2Idx <= '0;
        end else if (w_accept) begin
            r_rs1Idx <= o_rs1Addr;
            r_rs2Idx <= o_rs2Addr;
        end
    end
`else
    assign w_rs1Cap = i_rs1Data;
    assign w_rs2Cap = i_rs2Data;

    logic w_unused_wb;
    assign w_unused_wb = &{1'b0, i_wbEn, i_wbAddr, i_wbData};
`endif

    // ID/EX pipeline register: capture on accept, drain when execute takes it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_exValid    <= 1'b0;
            r_exPc       <= '0;
            r_exRs1Data  <= '0;
            r_exRs2Data  <= '0;
            r_exImm      <= '0;
            r_exRd       <= '0;
            r_exOpcode   <= '0;
            r_exFunct3   <= '0;
            r_exFunct7b5 <= 1'b0;
            r_exIllegal  <= 1'b0;
        end else if (i_flush) begin
            r_exValid <= 1'b0;
        end else if (w_accept) begin
            r_exValid    <= 1'b1;
            r_exPc       <= i_pc;
            r_exRs1Data  <= w_rs1Cap;
            r_exRs2Data  <= w_rs2Cap;
            r_exImm      <= w_imm;
            r_exRd       <= w_rd;
            r_exOpcode   <= i_instr[6:0];
            r_exFunct3   <= i_instr[14:12];
            r_exFunct7b5 <= i_instr[30];
            r_exIllegal  <= w_illegal;
        end else if (i_exReady) begin
            r_exValid <= 1'b0;
`ifdef ID_WB_BYPASS_EN
        end else if (r_exValid) begin
            if (i_wbEn && i_wbAddr != '0 && i_wbAddr == r_rs1Idx)
                r_exRs1Data <= i_wbData;
            if (i_wbEn && i_wbAddr != '0 && i_wbAddr == r_rs2Idx)
                r_exRs2Data <= i_wbData;
`endif
        end
    end

    assign o_exValid    = r_exValid;
    assign o_exPc       = r_exPc;
    assign o_exRs1Data  = r_exRs1Data;
    assign o_exRs2Data  = r_exRs2Data;
    assign o_exImm      = r_exImm;
    assign o_exRd       = r_exRd;
    assign o_exOpcode   = r_exOpcode;
    assign o_exFunct3   = r_exFunct3;
    assign o_exFunct7b5 = r_exFunct7b5;
    assign o_exIllegal  = r_exIllegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Directed self-checking bench for id_stage
//  Options  : ID_WB_BYPASS_EN selects the forwarding expectations
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    logic                  i_clk = 1'b0;
    logic                  i_reset;
    logic                  i_flush;
    logic                  i_instrValid;
    logic                  o_instrReady;
    logic [XLEN-1:0]       i_instr;
    logic [XLEN-1:0]       i_pc;
    logic [REG_ADDR_W-1:0] o_rs1Addr;
    logic [REG_ADDR_W-1:0] o_rs2Addr;
    logic [XLEN-1:0]       i_rs1Data;
    logic [XLEN-1:0]       i_rs2Data;
    logic                  i_wbEn;
    logic [REG_ADDR_W-1:0] i_wbAddr;
    logic [XLEN-1:0]       i_wbData;
    logic                  o_exValid;
    logic                  i_exReady;
    logic [XLEN-1:0]       o_exPc;
    logic [XLEN-1:0]       o_exRs1Data;
    logic [XLEN-1:0]       o_exRs2Data;
    logic [XLEN-1:0]       o_exImm;
    logic [REG_ADDR_W-1:0] o_exRd;
    logic [6:0]            o_exOpcode;
    logic [2:0]            o_exFunct3;
    logic                  o_exFunct7b5;
    logic                  o_exIllegal;

    int r_nCmp = 0;
    int r_nErr = 0;

    id_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_instrValid (i_instrValid),
        .o_instrReady (o_instrReady),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .o_rs1Addr    (o_rs1Addr),
        .o_rs2Addr    (o_rs2Addr),
        .i_rs1Data    (i_rs1Data),
        .i_rs2Data    (i_rs2Data),
        .i_wbEn       (i_wbEn),
        .i_wbAddr     (i_wbAddr),
        .i_wbData     (i_wbData),
        .o_exValid    (o_exValid),
        .i_exReady    (i_exReady),
        .o_exPc       (o_exPc),
        .o_exRs1Data  (o_exRs1Data),
        .o_exRs2Data  (o_exRs2Data),
        .o_exImm      (o_exImm),
        .o_exRd       (o_exRd),
        .o_exOpcode   (o_exOpcode),
        .o_exFunct3   (o_exFunct3),
        .o_exFunct7b5 (o_exFunct7b5),
        .o_exIllegal  (o_exIllegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_nCmp++;
        if (obs !== exp) begin
            r_nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling or driving
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present an instruction for one cycle with execute ready
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        i_instr      = instr;
        i_pc         = pc;
        i_instrValid = 1'b1;
        i_exReady    = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] w_expRs1;
        i_reset      = 1'b1;
        i_flush      = 1'b0;
        i_instrValid = 1'b1;
        i_instr      = 32'hFFF0_8293;
        i_pc         = 32'h0000_0100;
        i_rs1Data    = 32'h0000_0010;
        i_rs2Data    = 32'h0000_0000;
        i_wbEn       = 1'b0;
        i_wbAddr     = '0;
        i_wbData     = '0;
        i_exReady    = 1'b1;

        // Reset held two cycles with a valid instruction present
        step();
        step();
        check("rst_valid", {31'b0, o_exValid}, 32'h0);
        check("rst_pc",    o_exPc,             32'h0);
        check("rst_imm",   o_exImm,            32'h0);
        check("rst_rd",    {27'b0, o_exRd},    32'h0);
        check("rst_rs1",   o_exRs1Data,        32'h0);
        check("rst_op",    {25'b0, o_exOpcode}, 32'h0);
        i_reset = 1'b0;

        // addi x5,x1,-1
        #1;
        check("addi_rs1a", {27'b0, o_rs1Addr}, 32'd1);
        step();
        check("addi_valid", {31'b0, o_exValid},   32'h1);
        check("addi_rd",    {27'b0, o_exRd},      32'd5);
        check("addi_imm",   o_exImm,              32'hFFFF_FFFF);
        check("addi_rs1d",  o_exRs1Data,          32'h0000_0010);
        check("addi_ill",   {31'b0, o_exIllegal}, 32'h0);
        check("addi_pc",    o_exPc,               32'h0000_0100);
        check("addi_op",    {25'b0, o_exOpcode},  32'h13);

        // sw x2,8(x3)
        i_instr   = 32'h0021_A423;
        i_pc      = 32'h0000_0104;
        i_rs1Data = 32'h0000_0020;
        i_rs2Data = 32'h0000_0030;
        #1;
        check("sw_rs1a", {27'b0, o_rs1Addr}, 32'd3);
        check("sw_rs2a", {27'b0, o_rs2Addr}, 32'd2);
        step();
        check("sw_imm",  o_exImm,             32'd8);
        check("sw_rd",   {27'b0, o_exRd},     32'd0);
        check("sw_f3",   {29'b0, o_exFunct3}, 32'd2);
        check("sw_rs2d", o_exRs2Data,         32'h0000_0030);

        // Backpressure: lui x10,0x12345 waits behind the held store
        i_exReady = 1'b0;
        i_instr   = 32'h1234_5537;
        i_pc      = 32'h0000_0108;
        #1;
        check("bp_ready", {31'b0, o_instrReady}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", {31'b0, o_exValid}, 32'h1);
            check("bp_pc",    o_exPc,             32'h0000_0104);
            check("bp_imm",   o_exImm,            32'd8);
        end
        i_exReady = 1'b1;
        #1;
        check("bp_ready1", {31'b0, o_instrReady}, 32'h1);
        step();
        check("lui_pc",  o_exPc,         32'h0000_0108);
        check("lui_imm", o_exImm,        32'h1234_5000);
        check("lui_rd",  {27'b0, o_exRd}, 32'd10);

        // Flush while the lui entry is held: input dropped, entry killed
        i_exReady = 1'b0;
        i_flush   = 1'b1;
        i_instr   = 32'h0000_007F;
        i_pc      = 32'h0000_010C;
        #1;
        check("fl_ready", {31'b0, o_instrReady}, 32'h0);
        step();
        check("fl_valid", {31'b0, o_exValid}, 32'h0);
        i_flush = 1'b0;
        i_instrValid = 1'b0;
        step();
        check("fl_nocap", {31'b0, o_exValid}, 32'h0);

        // Illegal opcode with a nonzero rd field
        issue(32'hFFFF_FFFF, 32'h0000_0110);
        check("ill_valid", {31'b0, o_exValid},   32'h1);
        check("ill_flag",  {31'b0, o_exIllegal}, 32'h1);
        check("ill_imm",   o_exImm,              32'h0);
        check("ill_rd",    {27'b0, o_exRd},      32'd0);
        issue(32'h0000_007F, 32'h0000_0114);
        check("ill7f_flag", {31'b0, o_exIllegal}, 32'h1);
        check("ill7f_imm",  o_exImm,              32'h0);

        // Remaining immediate formats
        issue(32'h0080_00EF, 32'h0000_0118);   // jal x1,8
        check("jal_imm", o_exImm,         32'd8);
        check("jal_rd",  {27'b0, o_exRd}, 32'd1);
        issue(32'hFE20_8EE3, 32'h0000_011C);   // beq x1,x2,-4
        check("beq_imm", o_exImm,         32'hFFFF_FFFC);
        check("beq_rd",  {27'b0, o_exRd}, 32'd0);
        issue(32'hFFFF_F297, 32'h0000_0120);   // auipc x5,0xFFFFF
        check("aui_imm", o_exImm,         32'hFFFF_F000);
        check("aui_rd",  {27'b0, o_exRd}, 32'd5);
        issue(32'h4020_81B3, 32'h0000_0124);   // sub x3,x1,x2
        check("sub_imm", o_exImm,               32'h0);
        check("sub_rd",  {27'b0, o_exRd},       32'd3);
        check("sub_f7",  {31'b0, o_exFunct7b5}, 32'h1);
        check("sub_ill", {31'b0, o_exIllegal},  32'h0);
        issue(32'h0020_81B3, 32'h0000_0128);   // add x3,x1,x2
        check("add_f7",  {31'b0, o_exFunct7b5}, 32'h0);

        // Writeback to rs1 during capture of addi x5,x1,-1
        i_rs1Data = 32'h0000_0010;
        i_wbEn    = 1'b1;
        i_wbAddr  = 5'd1;
        i_wbData  = 32'h0000_ABCD;
        issue(32'hFFF0_8293, 32'h0000_012C);
`ifdef ID_WB_BYPASS_EN
        w_expRs1 = 32'h0000_ABCD;
`else
        w_expRs1 = 32'h0000_0010;
`endif
        check("wb_cap", o_exRs1Data, w_expRs1);

        // Same entry stalled, new writeback to x1
        i_instrValid = 1'b0;
        i_exReady    = 1'b0;
        i_wbData     = 32'h0000_1234;
        step();
`ifdef ID_WB_BYPASS_EN
        w_expRs1 = 32'h0000_1234;
`endif
        check("wb_hold", o_exRs1Data, w_expRs1);
        check("wb_holdv", {31'b0, o_exValid}, 32'h1);

        // Writes to x0 never forward
        i_wbAddr = 5'd0;
        i_wbData = 32'h0000_5555;
        step();
        check("wb_x0", o_exRs1Data, w_expRs1);

        // Drain
        i_wbEn    = 1'b0;
        i_exReady = 1'b1;
        step();
        check("drain_valid", {31'b0, o_exValid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_nCmp, r_nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage sitting directly upstream of the general-purpose register file.
- Accepts fetched instructions over a valid/ready handshake and slices out rs1/rs2/rd. Drives the register-file read addresses, sign-extends the immediate, flags illegal opcodes.
- Registers the decoded bundle, including the operand data returned by the register file, into the ID/EX pipeline register.
- The execute stage consumes the bundle over a second valid/ready handshake.

Parameters:
- XLEN, 32, datapath width of PC, instruction, operands and immediate.
- REG_ADDR_W, 5, register index width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  kill the in-flight ID/EX entry and drop the input (branch redirect).
- i_instrValid  in  1  fetch has an instruction.
- o_instrReady  out  1  stage accepts the instruction this cycle.
- i_instr  in  XLEN  instruction word.
- i_pc  in  XLEN  instruction PC.
- o_rs1Addr  out  REG_ADDR_W  register-file read address 1, equal to i_instr[19:15].
- o_rs2Addr  out  REG_ADDR_W  register-file read address 2, equal to i_instr[24:20].
- i_rs1Data  in  XLEN  combinational read data for o_rs1Addr; returns 0 for x0.
- i_rs2Data  in  XLEN  combinational read data for o_rs2Addr.
- i_wbEn  in  1  writeback write enable.
- i_wbAddr  in  REG_ADDR_W  writeback destination.
- i_wbData  in  XLEN  writeback data.
- o_exValid  out  1  ID/EX entry valid.
- i_exReady  in  1  execute accepts the entry.
- o_exPc, o_exRs1Data, o_exRs2Data, o_exImm  out  XLEN each  registered payload.
- o_exRd  out  REG_ADDR_W  destination register; 0 for S/B types.
- o_exOpcode  out  7  opcode.
- o_exFunct3  out  3  funct3.
- o_exFunct7b5  out  1  i_instr[30].
- o_exIllegal  out  1  opcode is not a supported RV32I major opcode.

Behaviour:
- Reset: on a rising i_clk edge with i_reset=1, o_exValid and all o_ex* payload outputs go to 0. i_reset dominates i_flush and any handshake.
- Handshake:
  - o_instrReady = !o_exValid || i_exReady, forced to 0 while i_flush=1.
  - Accept occurs when i_instrValid && o_instrReady. Next edge: payload captured, o_exValid=1.
  - If there is no accept and i_exReady=1, o_exValid goes to 0 next edge.
  - Otherwise the entry holds; the payload is bit-stable while o_exValid && !i_exReady.
- Latency: 1 cycle from accept to o_exValid. Throughput is 1 instruction/cycle when i_exReady=1.
- Flush: next edge o_exValid=0; the input is not accepted that cycle. An entry handed to execute in the flush cycle is still considered consumed by execute.
- o_rs1Addr/o_rs2Addr are purely combinational from i_instr, driven regardless of i_instrValid.
- Immediate types by opcode, all sign-extended from bit 31:
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011, bit 0 = 0.
  - U: 0110111, 0010111, low 12 bits = 0.
  - J: 1101111, bit 0 = 0.
  - 0110011 (R type): immediate = 0.
  - Any other opcode: o_exIllegal=1, immediate = 0, o_exRd = 0.
- o_exRd = i_instr[11:7], except 0 for S, B and illegal opcodes.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- With it defined:
  - At capture, if i_wbEn and i_wbAddr != 0 and i_wbAddr matches o_rs1Addr (resp. o_rs2Addr), i_wbData replaces i_rs1Data (resp. i_rs2Data).
  - While an entry is held stalled, a writeback whose i_wbAddr matches the held rs1/rs2 index (nonzero) updates o_exRs1Data/o_exRs2Data at the next edge. This requires storing the held rs1/rs2 indices.
  - Writes to x0 never bypass.
- Without it:
  - Register-file data is captured unmodified.
  - Held data is not refreshed; the hazard unit is responsible for stalling.

Decomposition:
- Shared package rv32_pkg: opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC) and an enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- Sub-module: imm_gen, combinational (i_instr -> imm, type, illegal). The stage owns the handshake and the pipeline register.

Test Plan:
- Reset: i_reset=1 for 2 cycles with i_instrValid=1 -> o_exValid=0, all payload 0, no capture.
- i_instr=0xFFF08293 (addi x5,x1,-1), i_rs1Data=0x10, i_exReady=1 -> o_rs1Addr=1 same cycle. Next cycle: o_exValid=1, o_exRd=5, o_exImm=0xFFFFFFFF, o_exRs1Data=0x10, o_exIllegal=0.
- i_instr=0x0021A423 (sw x2,8(x3)) -> o_rs1Addr=3, o_rs2Addr=2; next cycle o_exImm=8, o_exRd=0, o_exFunct3=2.
- Backpressure: i_exReady=0 after a capture -> o_instrReady=0, payload unchanged for 5 cycles. Raise i_exReady -> next instruction captured one cycle later.
- i_flush=1 with i_instrValid=1 and an entry held -> next cycle o_exValid=0, input dropped. Opcode 0x7F -> o_exIllegal=1, o_exImm=0.
- ID_WB_BYPASS_EN:
  - i_wbEn=1, i_wbAddr=1, i_wbData=0xABCD during capture of rs1=1 -> o_exRs1Data=0xABCD.
  - Same write while stalled -> held data refreshed.
  - i_wbAddr=0 -> no change.
